// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector.
// Watches a qualified bit stream and flags every occurrence of an N-bit
// pattern. The pattern can be reloaded at run time. Parameters select
// overlapping or non-overlapping matching and Mealy or Moore output timing.
// A saturating counter tallies matches, and led mirrors the bit history.
//
// Input qualifier: din is consumed only on a rising clk edge where
// din_valid=1. There is no ready and no backpressure, so every valid bit is
// taken. pat_load has priority over din_valid, and reset has priority over both.
module seq_detect_param #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic [N-1:0]     led
);

  // fill must be able to hold the value N itself.
  localparam int             FW        = $clog2(N + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [FW-1:0]  FILL_ARM  = FW'(N - 1);

  logic [N-1:0]  hist;
  logic [N-1:0]  pat;
  logic [N-1:0]  window;
  logic [FW-1:0] fill;
  logic          hit;
  logic          dout_q;

  // window is the history as it would look after accepting the current bit.
  assign window = {hist[N-2:0], din};

  // A match needs N bits accepted since the last clear, with the newest bit
  // being the one presented now. Gating with reset keeps the Mealy output
  // quiet while reset is held, even on its first cycle.
  assign hit = reset & din_valid & ~pat_load & (fill >= FILL_ARM) & (window == pat);

  // History, fill level, active pattern and the saturating match counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= PATTERN;
      match_cnt <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
    end else if (din_valid) begin
      hist <= window;
      if (hit) begin
        if (match_cnt != {CNT_W{1'b1}}) begin
          match_cnt <= match_cnt + 1'b1;
        end
        // Non-overlap discards the history, so the next match needs N new bits.
        fill <= OVERLAP ? FILL_FULL : '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Registered copy of hit, used as dout in Moore mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= hit;
    end
  end

  assign dout = MOORE ? dout_q : hit;
  assign led  = hist;

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param.
// Three instances share one input stream:
//   u0: Mealy, N=3, pattern 101, overlapping matches
//   u1: Mealy, N=3, pattern 101, non-overlapping, 2-bit counter
//   u2: Moore, N=4, pattern 1101, overlapping matches
// A reference model keeps, for each instance, the list of bits received
// since the last clear and checks the tail of that list against the pattern.
module tb_seq_detect_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       din;
  logic       din_valid;
  logic       pat_load;
  logic [2:0] pin3;
  logic [3:0] pin4;

  logic       dout0, dout1, dout2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;
  logic [2:0] led0, led1;
  logic [3:0] led2;

  seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pin3), .dout(dout0), .match_cnt(cnt0), .led(led0));

  seq_detect_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pin3), .dout(dout1), .match_cnt(cnt1), .led(led1));

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pin4), .dout(dout2), .match_cnt(cnt2), .led(led2));

  // ---------------- reference model ----------------
  int m_n[3]       = '{3, 3, 4};
  int m_rst_pat[3] = '{5, 5, 13};
  bit m_ovl[3]     = '{1'b1, 1'b0, 1'b1};
  int m_cmax[3]    = '{255, 3, 255};

  int m_pat[3];
  int m_cnt[3];
  int m_led[3];
  bit sb[3][16];   // bits received since the last clear, oldest first
  int sn[3];       // number of entries held in sb (only the last N matter)
  bit m_moore_q;   // u2 output expected after the latest edge

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      sn[i]    = 0;
      m_led[i] = 0;
      m_pat[i] = m_rst_pat[i];
      m_cnt[i] = 0;
    end
    m_moore_q = 1'b0;
  endfunction

  function automatic void push(input int i, input bit b);
    if (sn[i] == m_n[i]) begin
      for (int k = 0; k < m_n[i] - 1; k++) sb[i][k] = sb[i][k+1];
      sb[i][m_n[i]-1] = b;
    end else begin
      sb[i][sn[i]] = b;
      sn[i]++;
    end
  endfunction

  // Does the current bit complete the pattern for instance i?
  function automatic bit model_hit(input int i, input bit r, input bit d, input bit v, input bit ld);
    int val;
    if (!r || !v || ld) return 1'b0;
    if (sn[i] < m_n[i] - 1) return 1'b0;
    val = 0;
    for (int k = sn[i] - (m_n[i] - 1); k < sn[i]; k++) val = (val << 1) | int'(sb[i][k]);
    val = (val << 1) | int'(d);
    return val == m_pat[i];
  endfunction

  // ---------------- driver ----------------
  // Drive inputs at the falling edge, check outputs, advance the model, then
  // return 1 time unit after the rising edge.
  task automatic step(input bit r, input bit d, input bit v, input bit ld,
                      input logic [2:0] p3 = 3'b0, input logic [3:0] p4 = 4'b0);
    bit h[3];
    @(negedge clk);
    reset = r; din = d; din_valid = v; pat_load = ld; pin3 = p3; pin4 = p4;
    #1;
    for (int i = 0; i < 3; i++) h[i] = model_hit(i, r, d, v, ld);
    check_eq("dout0", dout0, h[0]);
    check_eq("dout1", dout1, h[1]);
    check_eq("dout2", dout2, m_moore_q);
    check_eq("cnt0", cnt0, m_cnt[0]);
    check_eq("cnt1", cnt1, m_cnt[1]);
    check_eq("cnt2", cnt2, m_cnt[2]);
    check_eq("led0", led0, m_led[0]);
    check_eq("led1", led1, m_led[1]);
    check_eq("led2", led2, m_led[2]);
    if (!r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ld) begin
          m_pat[i] = (i == 2) ? int'(p4) : int'(p3);
          sn[i]    = 0;
          m_led[i] = 0;
        end else if (v) begin
          m_led[i] = ((m_led[i] << 1) | int'(d)) & ((1 << m_n[i]) - 1);
          if (h[i]) begin
            if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
            if (m_ovl[i]) push(i, d);
            else sn[i] = 0;
          end else begin
            push(i, d);
          end
        end
      end
      m_moore_q = h[2];
    end
    @(posedge clk);
    #1;
  endtask

  // Feed len valid bits, MSB first.
  task automatic feed(input logic [15:0] bits, input int len);
    for (int k = len - 1; k >= 0; k--) step(1'b1, bits[k], 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; din = 1'b0; din_valid = 1'b0; pat_load = 1'b0; pin3 = '0; pin4 = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic Mealy stream: hits on bits 3 and 8.
    feed(16'b1011110111, 10);
    check_eq("plan_basic_cnt", cnt0, 2);

    // Overlap vs. non-overlap.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b10101, 5);
    check_eq("overlap_cnt", cnt0, 2);
    check_eq("nonoverlap_cnt", cnt1, 1);

    // Moore N=4.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b1101, 4);
    check_eq("moore_led", led2, 4'b1101);
    check_eq("moore_dout", dout2, 1);

    // Gaps between valid bits.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("gap_cnt", cnt0, 1);

    // Pattern reload together with a valid bit, then 0,1,1.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 4'b0011);
    check_eq("load_led", led0, 0);
    feed(16'b011, 3);
    check_eq("load_cnt", cnt0, 2);

    // Reset mid-pattern.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b10, 2);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("rst_led", led0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("rst_cnt", cnt0, 0);

    // Counter saturation: five non-overlapping matches on a 2-bit counter.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    feed(16'b101101101101101, 15);
    check_eq("sat_cnt1", cnt1, 3);
    check_eq("sat_cnt0", cnt0, 5);

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      step(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
